// File: rtl/decision_forest.sv
// Parallel decision-tree walker: each tree fetches one node per cycle from its own
// synchronous memory, and the per-tree verdicts are majority-voted into a drop decision.
// state | meaning
// IDLE  | ready, root address 0 prefetched on every tree
// WALK  | unfinished trees evaluate one node per cycle
// VOTE  | done pulse, verdict registers freshly loaded
module decision_forest #(
  parameter int N_TREES   = 3,
  parameter int ADDR_W    = 8,
  parameter int THR_W     = 16,
  parameter int N_FEAT    = 12,
  parameter int VOTE_THR  = 2,
  parameter int MAX_STEPS = 32,
  localparam int NODE_W   = 4 + THR_W + 2*ADDR_W,
  localparam int VOTE_W   = $clog2(N_TREES+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_FEAT*THR_W-1:0]   features,
  output logic                      ready,
  output logic [N_TREES*ADDR_W-1:0] mem_addr,
  input  logic [N_TREES*NODE_W-1:0] mem_data,
  output logic                      done,
  output logic                      drop_pkg,
  output logic [VOTE_W-1:0]         drop_votes,
  output logic [N_TREES-1:0]        timeout_mask
);

  localparam int STEP_W = $clog2(MAX_STEPS+1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
  localparam logic [VOTE_W-1:0] VOTE_MIN = VOTE_W'(VOTE_THR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_VOTE = 2'd2;

  logic [1:0]              r_state;
  logic [N_FEAT*THR_W-1:0] r_feat;
  logic [ADDR_W-1:0]       r_addr [N_TREES];
  logic [STEP_W-1:0]       r_step [N_TREES];
  logic [N_TREES-1:0]      r_fin, r_verd, r_tmo;
  logic                    r_drop;
  logic [VOTE_W-1:0]       r_votes;
  logic [N_TREES-1:0]      r_tmo_mask;

  logic [THR_W-1:0]        w_feat [16];
  logic [3:0]              w_fidx [N_TREES];
  logic [THR_W-1:0]        w_thr  [N_TREES];
  logic [ADDR_W-1:0]       w_pt   [N_TREES];
  logic [ADDR_W-1:0]       w_pf   [N_TREES];
  logic [N_TREES-1:0]      w_cmp;
  logic [ADDR_W-1:0]       w_addr_nxt [N_TREES];
  logic [STEP_W-1:0]       w_step_nxt [N_TREES];
  logic [N_TREES-1:0]      w_fin_nxt, w_verd_nxt, w_tmo_nxt;
  logic [VOTE_W-1:0]       w_votes;

  // Feature indices past N_FEAT read as zero.
  for (genvar k = 0; k < 16; k++) begin : g_feat
    if (k < N_FEAT) begin : g_real
      assign w_feat[k] = r_feat[k*THR_W +: THR_W];
    end else begin : g_zero
      assign w_feat[k] = '0;
    end
  end

  for (genvar i = 0; i < N_TREES; i++) begin : g_tree
    assign w_fidx[i] = mem_data[i*NODE_W + THR_W + 2*ADDR_W +: 4];
    assign w_thr[i]  = mem_data[i*NODE_W + 2*ADDR_W +: THR_W];
    assign w_pt[i]   = mem_data[i*NODE_W + ADDR_W +: ADDR_W];
    assign w_pf[i]   = mem_data[i*NODE_W +: ADDR_W];
    assign w_cmp[i]  = w_feat[w_fidx[i]] < w_thr[i];
  end

  always_comb begin
    w_fin_nxt  = r_fin;
    w_verd_nxt = r_verd;
    w_tmo_nxt  = r_tmo;
    mem_addr   = '0;
    for (int i = 0; i < N_TREES; i++) begin
      w_addr_nxt[i] = r_addr[i];
      w_step_nxt[i] = r_step[i];
      if (r_state == S_WALK && !r_fin[i]) begin
        if (&w_thr[i]) begin
          w_fin_nxt[i]  = 1'b1;
          w_verd_nxt[i] = (w_pt[i] == '0);
        end else if (r_step[i] == STEP_MAX) begin
          // Runaway walk is treated as a drop vote.
          w_fin_nxt[i]  = 1'b1;
          w_verd_nxt[i] = 1'b1;
          w_tmo_nxt[i]  = 1'b1;
        end else begin
          w_step_nxt[i] = r_step[i] + 1'b1;
          if (!w_cmp[i])
            w_addr_nxt[i] = w_pf[i];
          else if (w_pt[i] != '0)
            w_addr_nxt[i] = w_pt[i];
          else
            w_addr_nxt[i] = r_addr[i] + 1'b1;
        end
      end
      mem_addr[i*ADDR_W +: ADDR_W] = (r_state == S_IDLE) ? '0 : w_addr_nxt[i];
    end
  end

  always_comb begin
    w_votes = '0;
    for (int i = 0; i < N_TREES; i++)
      w_votes = w_votes + VOTE_W'(w_verd_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_feat     <= '0;
      r_fin      <= '0;
      r_verd     <= '0;
      r_tmo      <= '0;
      r_drop     <= 1'b0;
      r_votes    <= '0;
      r_tmo_mask <= '0;
      for (int i = 0; i < N_TREES; i++) begin
        r_addr[i] <= '0;
        r_step[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_WALK;
            r_feat     <= features;
            r_fin      <= '0;
            r_verd     <= '0;
            r_tmo      <= '0;
            r_drop     <= 1'b0;
            r_votes    <= '0;
            r_tmo_mask <= '0;
            for (int i = 0; i < N_TREES; i++) begin
              r_addr[i] <= '0;
              r_step[i] <= '0;
            end
          end
        end
        S_WALK: begin
          r_fin  <= w_fin_nxt;
          r_verd <= w_verd_nxt;
          r_tmo  <= w_tmo_nxt;
          for (int i = 0; i < N_TREES; i++) begin
            r_addr[i] <= w_addr_nxt[i];
            r_step[i] <= w_step_nxt[i];
          end
          if (&w_fin_nxt) begin
            r_state    <= S_VOTE;
            r_votes    <= w_votes;
            r_drop     <= (w_votes >= VOTE_MIN);
            r_tmo_mask <= w_tmo_nxt;
          end
        end
        S_VOTE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready        = (r_state == S_IDLE);
  assign done         = (r_state == S_VOTE);
  assign drop_pkg     = r_drop;
  assign drop_votes   = r_votes;
  assign timeout_mask = r_tmo_mask;

endmodule

// File: tb/tb_decision_forest.sv
// Bench for decision_forest: directed tables and sequences plus random trees checked
// against a tree-walking reference model over a bench-owned node memory.
module tb_decision_forest;
  localparam int NT = 3, AW = 8, TW = 16, NF = 12, MS = 32, NW = 4 + TW + 2*AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NF*TW-1:0]  features = '0;
  logic              ready, done, drop_pkg;
  logic [NT*AW-1:0]  mem_addr;
  logic [NT*NW-1:0]  mem_data = '0;
  logic [1:0]        drop_votes;
  logic [NT-1:0]     timeout_mask;

  logic [NW-1:0]     mem [NT][256];
  int                n_chk = 0, n_fail = 0;
  logic [AW-1:0]     a1, a2;

  typedef struct {
    logic [15:0] f0;
    logic        t1_drop;
    logic        exp_drop;
    logic [1:0]  exp_votes;
    int          exp_cyc;
  } vec_t;
  vec_t vecs [6];

  decision_forest dut (
    .clk(clk), .rst(rst), .start(start), .features(features), .ready(ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .done(done), .drop_pkg(drop_pkg),
    .drop_votes(drop_votes), .timeout_mask(timeout_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int t = 0; t < NT; t++)
      mem_data[t*NW +: NW] <= mem[t][mem_addr[t*AW +: AW]];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk(input int fi, input int thr, input int pt, input int pf);
    return {4'(fi), 16'(thr), 8'(pt), 8'(pf)};
  endfunction

  task automatic clear_mem();
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < 256; a++)
        mem[t][a] = mk(0, 16'hFFFF, 1, 0);
  endtask

  task automatic set_feat(input int k, input logic [15:0] v);
    features[k*TW +: TW] = v;
  endtask

  // Walks one tree the way the algorithm describes it; steps = internal nodes visited.
  function automatic void model(input int t, input logic [NF*TW-1:0] f,
                                output logic verd, output logic tmo, output int steps);
    int addr, fi, thr, pt, pf, fv;
    addr = 0; verd = 1'b0; tmo = 1'b0; steps = 0;
    for (int k = 0; k <= MS; k++) begin
      fi  = int'(mem[t][addr][35:32]);
      thr = int'(mem[t][addr][31:16]);
      pt  = int'(mem[t][addr][15:8]);
      pf  = int'(mem[t][addr][7:0]);
      if (thr == 65535) begin
        verd = (pt == 0); steps = k; return;
      end
      if (k == MS) begin
        verd = 1'b1; tmo = 1'b1; steps = k; return;
      end
      fv = (fi < NF) ? int'(f[fi*TW +: TW]) : 0;
      if (fv < thr) addr = (pt != 0) ? pt : (addr + 1) % 256;
      else          addr = pf;
    end
  endfunction

  // Called just after a rising edge with the DUT idle; cycle 0 is the start cycle.
  task automatic run(input bit inject, output int cyc, output logic d,
                     output logic [1:0] v, output logic [2:0] m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    a1 = mem_addr[AW-1:0];
    chk("ready_low_in_walk", ready, 0);
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) a2 = mem_addr[AW-1:0];
      if (inject && cyc == 5) begin start = 1'b1; set_feat(0, 16'd3); end
      if (inject && cyc == 6) start = 1'b0;
    end
    chk("done_seen", done, 1);
    d = drop_pkg; v = drop_votes; m = timeout_mask;
    if (inject) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("ready_after_vote", ready, 1);
  endtask

  task automatic idle_watch(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    int cyc, pulses, ms, st;
    logic d, vd, tm;
    logic [1:0] v, ev;
    logic [2:0] m, em;

    vecs[0] = '{16'd99,    1'b0, 1'b0, 2'd0, 3};
    vecs[1] = '{16'd100,   1'b0, 1'b0, 2'd1, 3};
    vecs[2] = '{16'd0,     1'b0, 1'b0, 2'd0, 3};
    vecs[3] = '{16'hFFFF,  1'b0, 1'b0, 2'd1, 3};
    vecs[4] = '{16'd100,   1'b1, 1'b1, 2'd2, 3};
    vecs[5] = '{16'd99,    1'b1, 1'b0, 2'd1, 3};

    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_drop", drop_pkg, 0);
    chk("rst_votes", drop_votes, 0);
    chk("rst_tmo", timeout_mask, 0);
    chk("idle_addr", mem_addr, 0);

    // All roots are drop leaves.
    for (int t = 0; t < NT; t++) mem[t][0] = mk(0, 16'hFFFF, 0, 0);
    run(0, cyc, d, v, m);
    chk("leaf_cyc", cyc, 2);
    chk("leaf_votes", v, 3);
    chk("leaf_drop", d, 1);
    chk("leaf_tmo", m, 0);

    // Single-comparison threshold table.
    for (int i = 0; i < 6; i++) begin
      clear_mem();
      mem[0][0] = mk(0, 100, 5, 9);
      mem[0][5] = mk(0, 16'hFFFF, 1, 0);
      mem[0][9] = mk(0, 16'hFFFF, 0, 0);
      if (vecs[i].t1_drop) mem[1][0] = mk(0, 16'hFFFF, 0, 0);
      set_feat(0, vecs[i].f0);
      run(0, cyc, d, v, m);
      chk($sformatf("tbl%0d_cyc", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("tbl%0d_votes", i), v, vecs[i].exp_votes);
      chk($sformatf("tbl%0d_drop", i), d, vecs[i].exp_drop);
    end

    // Depth-4 path on tree1, including ptr_true==0 fall-through and an out-of-range feature.
    clear_mem();
    features = '0;
    set_feat(1, 16'd10);
    set_feat(2, 16'd9);
    mem[1][0] = mk(1, 50, 0, 8'h40);
    mem[1][1] = mk(2, 5, 8'h30, 2);
    mem[1][2] = mk(13, 1, 3, 8'h50);
    mem[1][3] = mk(1, 11, 0, 8'h60);
    mem[1][4] = mk(0, 16'hFFFF, 0, 0);
    run(0, cyc, d, v, m);
    chk("depth_cyc", cyc, 6);
    chk("depth_votes", v, 1);
    chk("depth_drop", d, 0);

    // Address wrap 0xFF -> 0x00 on tree0, which then loops until timeout.
    clear_mem();
    features = '0;
    mem[0][0]     = mk(0, 16'h8000, 8'hFF, 8'h20);
    mem[0][8'hFF] = mk(0, 16'h8000, 0, 8'h20);
    run(0, cyc, d, v, m);
    chk("wrap_addr_c1", a1, 8'hFF);
    chk("wrap_addr_c2", a2, 8'h00);
    chk("wrap_cyc", cyc, 34);
    chk("wrap_tmo", m, 3'b001);
    chk("wrap_votes", v, 1);

    // Self-loop on tree2 with ignored starts mid-walk and on the done cycle.
    clear_mem();
    features = '0;
    set_feat(0, 16'd20);
    mem[0][0]     = mk(0, 16'hFFFF, 0, 0);
    mem[2][0]     = mk(0, 10, 8'h40, 0);
    mem[2][8'h40] = mk(0, 16'hFFFF, 1, 0);
    run(1, cyc, d, v, m);
    chk("loop_cyc", cyc, 34);
    chk("loop_tmo", m, 3'b100);
    chk("loop_votes", v, 2);
    chk("loop_drop", d, 1);
    idle_watch(40, pulses);
    chk("loop_extra_done", pulses, 0);
    chk("loop_ready_held", ready, 1);
    chk("loop_drop_held", drop_pkg, 1);
    chk("loop_votes_held", drop_votes, 2);

    // Reset in cycle 3 of a walk.
    set_feat(0, 16'd20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_drop", drop_pkg, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_done", done, 0);
    chk("post_rst_votes", drop_votes, 0);
    chk("post_rst_tmo", timeout_mask, 0);
    idle_watch(40, pulses);
    chk("post_rst_no_done", pulses, 0);
    for (int t = 0; t < NT; t++) mem[t][0] = mk(0, 16'hFFFF, 0, 0);
    run(0, cyc, d, v, m);
    chk("fresh_cyc", cyc, 2);
    chk("fresh_votes", v, 3);

    // Random forests against the reference model.
    for (int it = 0; it < 25; it++) begin
      for (int t = 0; t < NT; t++)
        for (int a = 0; a < 256; a++) begin
          if ($urandom_range(0, 2) == 0)
            mem[t][a] = mk(0, 16'hFFFF, $urandom_range(0, 1), $urandom_range(0, 255));
          else
            mem[t][a] = mk($urandom_range(0, 15), $urandom_range(0, 16'hFFFE),
                           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
                           $urandom_range(0, 255));
        end
      for (int k = 0; k < NF; k++) set_feat(k, 16'($urandom));
      ev = '0; em = '0; ms = 0;
      for (int t = 0; t < NT; t++) begin
        model(t, features, vd, tm, st);
        ev += 2'(vd);
        em[t] = tm;
        if (st > ms) ms = st;
      end
      run(0, cyc, d, v, m);
      chk($sformatf("rnd%0d_cyc", it), cyc, ms + 2);
      chk($sformatf("rnd%0d_votes", it), v, ev);
      chk($sformatf("rnd%0d_drop", it), d, (ev >= 2));
      chk($sformatf("rnd%0d_tmo", it), m, em);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decision_forest.md
DECISION_FOREST -- requirements
Module: decision_forest

Interface
REQ-001 Parameter N_TREES, default 3: number of trees evaluated in parallel (1..8).
REQ-002 Parameter ADDR_W, default 8: node address width per tree memory.
REQ-003 Parameter THR_W, default 16: feature and threshold width.
REQ-004 Parameter N_FEAT, default 12: number of header features.
REQ-005 Parameter VOTE_THR, default 2: minimum drop votes for a drop verdict (1..N_TREES).
REQ-006 Parameter MAX_STEPS, default 32: internal-node evaluations allowed per tree before timeout.
REQ-007 Derived NODE_W = 4+THR_W+2*ADDR_W; node word = {feat_idx[3:0], threshold[THR_W-1:0], ptr_true[ADDR_W-1:0], ptr_false[ADDR_W-1:0]} (MSB first).
REQ-008 clk  input  1  clock; all state on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 start  input  1  request pulse; accepted only when ready=1.
REQ-011 features  input  N_FEAT*THR_W  flattened feature vector; feature k = bits [k*THR_W +: THR_W].
REQ-012 ready  output  1  high in IDLE only.
REQ-013 mem_addr  output  N_TREES*ADDR_W  per-tree node address (combinational), tree i at [i*ADDR_W +: ADDR_W].
REQ-014 mem_data  input  N_TREES*NODE_W  per-tree node word; synchronous memory, data valid the cycle after its address.
REQ-015 done  output  1  one-cycle pulse when a verdict is produced.
REQ-016 drop_pkg  output  1  verdict, registered, held until next accepted start.
REQ-017 drop_votes  output  $clog2(N_TREES+1)  count of trees voting drop, held like drop_pkg.
REQ-018 timeout_mask  output  N_TREES  bit i set if tree i timed out, held like drop_pkg.

Function
REQ-019 FSM states IDLE, WALK, VOTE; IDLE->WALK on start; WALK->VOTE when every tree is finished; VOTE->IDLE unconditionally.
REQ-020 On accepted start: features latched into an internal register; all per-tree step counters, finished flags, and verdicts are cleared; drop_pkg, drop_votes, and timeout_mask are cleared.
REQ-021 In IDLE, mem_addr of every tree is 0 (root prefetch), so the root word is present in the first WALK cycle.
REQ-022 In WALK, each unfinished tree evaluates one node per cycle from its mem_data.
REQ-023 A node is a leaf when its threshold field is all ones; tree verdict = drop if ptr_true == 0, else pass; the tree is then marked finished.
REQ-024 Internal node: cmp = (latched feature[feat_idx] < threshold), unsigned; feat_idx >= N_FEAT selects the value 0.
REQ-025 Next address: cmp=0 -> ptr_false; cmp=1 and ptr_true != 0 -> ptr_true; cmp=1 and ptr_true == 0 -> current address + 1 (mod 2^ADDR_W).
REQ-026 The next address drives mem_addr combinationally in the same cycle and is registered as that tree's current address.
REQ-027 Each internal-node evaluation increments the tree's step counter; on reaching MAX_STEPS without a leaf, the tree finishes with verdict drop and its timeout bit set (fail-closed).
REQ-028 A finished tree holds its mem_addr and verdict and is not re-evaluated until the next start.
REQ-029 On the WALK->VOTE transition, drop_votes = number of drop verdicts, drop_pkg = (drop_votes >= VOTE_THR), and timeout_mask is registered.
REQ-030 done is high for exactly the VOTE cycle; drop_pkg, drop_votes, and timeout_mask are valid from that cycle onward.
REQ-031 Latency: start in cycle 0, longest tree path with d internal nodes -> leaf evaluated in cycle d+1, done in cycle d+2; ready returns in cycle d+3.
REQ-032 start while ready=0 (WALK or VOTE, including the done cycle) is ignored and has no side effects.
REQ-033 Changes on features after the start cycle have no effect on the verdict in progress.

Reset
REQ-034 rst asserted forces state IDLE, ready=1, done=0, drop_pkg=0, drop_votes=0, and timeout_mask=0, and clears counters and latched features, regardless of state.
REQ-035 Reset mid-WALK abandons the evaluation with no done pulse; the next start after release behaves as a fresh request.

Verification
REQ-036 N_TREES=3; all roots are leaves with ptr_true=0; start -> done in cycle 2, drop_votes=3, drop_pkg=1.
REQ-037 Tree0 root has feat 0, threshold 100, ptr_true=5 (leaf pass), ptr_false=9 (leaf drop); other trees are pass leaves; feature0=99 -> drop_pkg=0 and drop_votes=0; feature0=100 -> drop_votes=1, drop_pkg=0.
REQ-038 Tree1 path depth 4 and others depth 1 -> done in cycle 6; ptr_true=0 on an internal node with cmp=1 fetches current+1, checked at address 0xFF wrapping to 0x00.
REQ-039 Tree2 contains a self-loop (ptr_false = own address), MAX_STEPS=32 -> done in cycle 34, timeout_mask=3'b100, tree counted as a drop vote.
REQ-040 Start pulsed during WALK and on the done cycle -> ignored, single done pulse; rst in cycle 3 of a walk -> no done, outputs 0, ready=1 on the next cycle.
